// File: rtl/lock_pkg.sv
// Shared constants, digit helpers and entry-FSM state encoding for the lock front end.
package lock_pkg;

  localparam int DIGIT_W   = 4;
  localparam int DIGIT_MAX = 9;
  localparam int USER_LEN  = 4;
  localparam int PASS_LEN  = 4;
  localparam int ENTRY_LEN = USER_LEN + PASS_LEN;

  typedef enum logic {
    StEntry,
    StFull
  } entry_state_t;

  function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
    return (d >= DIGIT_W'(DIGIT_MAX)) ? '0 : d + DIGIT_W'(1);
  endfunction

  function automatic logic [DIGIT_W-1:0] digit_dec(input logic [DIGIT_W-1:0] d);
    return (d == '0) ? DIGIT_W'(DIGIT_MAX) : d - DIGIT_W'(1);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Two-flop synchronizer, hold-count debouncer and rising-edge pulse for one raw input.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_sync;
  logic [1:0]      r_vld;
  logic [CntW-1:0] r_cnt;
  logic            r_level;
  logic            r_armed;
  logic            r_pulse;

  // A press is only armed once a genuine low has been observed after reset, so a
  // button held through reset never produces a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_vld   <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_armed <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_vld   <= {r_vld[0], 1'b1};
      r_pulse <= 1'b0;
      if (r_vld[1] && !r_sync[1]) begin
        r_armed <= 1'b1;
      end
      if (r_sync[1] != r_level) begin
        if (r_cnt == CntMax) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
          r_pulse <= r_sync[1] & r_armed;
        end else begin
          r_cnt <= r_cnt + CntW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/credential_entry.sv
// Button-driven digit entry for the lock; optional idle timeout under `ENTRY_TIMEOUT_EN`.
module credential_entry
  import lock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  input  logic       btn4,
  input  logic       btn5,
  input  logic       switch1,
  input  logic       resetCount,
  output logic [3:0] inputCount,
  output logic [3:0] userNameInput0,
  output logic [3:0] userNameInput1,
  output logic [3:0] userNameInput2,
  output logic [3:0] userNameInput3,
  output logic [3:0] passwordInput0,
  output logic [3:0] passwordInput1,
  output logic [3:0] passwordInput2,
  output logic [3:0] passwordInput3,
  output logic [3:0] editDigit,
  output logic       entryFull
);

  logic [4:0] w_raw;
  logic [4:0] w_btn_pulse;
  logic [4:0] w_btn_level_unused;
  logic       w_sw_level;
  logic       w_sw_pulse_unused;
  logic [4:0] w_pulse;
  logic       w_timeout;
  logic [2:0] w_bs_idx;

  entry_state_t        r_state;
  logic [3:0]          r_count;
  logic [DIGIT_W-1:0]  r_edit;
  logic [DIGIT_W-1:0]  r_slot [ENTRY_LEN];

  assign w_raw = {btn5, btn4, btn3, btn2, btn1};

  for (genvar g = 0; g < 5; g++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_raw  (w_raw[g]),
      .o_level(w_btn_level_unused[g]),
      .o_pulse(w_btn_pulse[g])
    );
  end

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_raw  (switch1),
    .o_level(w_sw_level),
    .o_pulse(w_sw_pulse_unused)
  );

  assign w_pulse  = w_btn_pulse & {5{w_sw_level}};
  assign w_bs_idx = 3'(r_count - 4'd1);

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IdleW-1:0] r_idle;
  logic             w_idle_hold;

  // Only a partial entry ages; empty and full entries hold the counter at zero.
  assign w_idle_hold = (|w_pulse) || resetCount || (r_count == 4'd0) ||
                       (r_count == 4'(ENTRY_LEN));
  assign w_timeout   = !w_idle_hold && (r_idle == IdleW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (w_idle_hold || w_timeout) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IdleW'(1);
    end
  end
`else
  localparam int unsigned TimeoutUnused = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  // Priority: resetCount/clear/timeout > backspace > commit > increment > decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEntry;
      r_count <= '0;
      r_edit  <= '0;
      for (int i = 0; i < ENTRY_LEN; i++) r_slot[i] <= '0;
    end else if (resetCount || w_pulse[4] || w_timeout) begin
      r_state <= StEntry;
      r_count <= '0;
      r_edit  <= '0;
      for (int i = 0; i < ENTRY_LEN; i++) r_slot[i] <= '0;
    end else if (w_pulse[3]) begin
      if (r_count != 4'd0) begin
        r_count          <= r_count - 4'd1;
        r_slot[w_bs_idx] <= '0;
        r_edit           <= '0;
        r_state          <= StEntry;
      end
    end else if (w_pulse[2]) begin
      if (r_state == StEntry) begin
        r_slot[r_count[2:0]] <= r_edit;
        r_count              <= r_count + 4'd1;
        r_edit               <= '0;
        if (r_count == 4'(ENTRY_LEN - 1)) begin
          r_state <= StFull;
        end
      end
    end else if (w_pulse[0]) begin
      r_edit <= digit_inc(r_edit);
    end else if (w_pulse[1]) begin
      r_edit <= digit_dec(r_edit);
    end
  end

  assign inputCount     = r_count;
  assign editDigit      = r_edit;
  assign entryFull      = (r_state == StFull);
  assign userNameInput0 = r_slot[0];
  assign userNameInput1 = r_slot[1];
  assign userNameInput2 = r_slot[2];
  assign userNameInput3 = r_slot[3];
  assign passwordInput0 = r_slot[4];
  assign passwordInput1 = r_slot[5];
  assign passwordInput2 = r_slot[6];
  assign passwordInput3 = r_slot[7];

endmodule

// File: tb/tb_credential_entry.sv
// Randomized and directed checks of credential_entry against an abstract entry model.
module tb_credential_entry;

  logic       clk;
  logic       rst_n;
  logic       btn1, btn2, btn3, btn4, btn5, switch1, resetCount;
  logic [3:0] inputCount, editDigit;
  logic [3:0] userNameInput0, userNameInput1, userNameInput2, userNameInput3;
  logic [3:0] passwordInput0, passwordInput1, passwordInput2, passwordInput3;
  logic       entryFull;
  logic [3:0] w_slot [8];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the entry as a list of committed digits plus the digit being composed.
  int m_slot [8];
  int m_count;
  int m_edit;

  credential_entry #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (40)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn1          (btn1),
    .btn2          (btn2),
    .btn3          (btn3),
    .btn4          (btn4),
    .btn5          (btn5),
    .switch1       (switch1),
    .resetCount    (resetCount),
    .inputCount    (inputCount),
    .userNameInput0(userNameInput0),
    .userNameInput1(userNameInput1),
    .userNameInput2(userNameInput2),
    .userNameInput3(userNameInput3),
    .passwordInput0(passwordInput0),
    .passwordInput1(passwordInput1),
    .passwordInput2(passwordInput2),
    .passwordInput3(passwordInput3),
    .editDigit     (editDigit),
    .entryFull     (entryFull)
  );

  assign w_slot[0] = userNameInput0;
  assign w_slot[1] = userNameInput1;
  assign w_slot[2] = userNameInput2;
  assign w_slot[3] = userNameInput3;
  assign w_slot[4] = passwordInput0;
  assign w_slot[5] = passwordInput1;
  assign w_slot[6] = passwordInput2;
  assign w_slot[7] = passwordInput3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_count = 0;
    m_edit  = 0;
    for (int i = 0; i < 8; i++) m_slot[i] = 0;
  endtask

  task automatic model_event(input int b);
    case (b)
      1: m_edit = (m_edit + 1) % 10;
      2: m_edit = (m_edit + 9) % 10;
      3: if (m_count < 8) begin
           m_slot[m_count] = m_edit;
           m_count++;
           m_edit = 0;
         end
      4: if (m_count > 0) begin
           m_count--;
           m_slot[m_count] = 0;
           m_edit = 0;
         end
      5: model_clear();
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, " count"}, int'(inputCount), m_count);
    check_eq({tag, " edit"}, int'(editDigit), m_edit);
    check_eq({tag, " full"}, int'(entryFull), (m_count == 8) ? 1 : 0);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("%s slot%0d", tag, i), int'(w_slot[i]), m_slot[i]);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      1: btn1 = v;
      2: btn2 = v;
      3: btn3 = v;
      4: btn4 = v;
      5: btn5 = v;
      default: ;
    endcase
  endtask

  task automatic press(input int b, input int hold);
    set_btn(b, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  // Press with the accept edge checked: unchanged after 6 edges, updated after 7.
  task automatic press_timed(input int b);
    int old_cnt;
    int old_edit;
    old_cnt  = m_count;
    old_edit = m_edit;
    set_btn(b, 1'b1);
    repeat (6) @(negedge clk);
    check_eq("latency early count", int'(inputCount), old_cnt);
    check_eq("latency early edit", int'(editDigit), old_edit);
    @(negedge clk);
    model_event(b);
    check_eq("latency count", int'(inputCount), m_count);
    check_eq("latency edit", int'(editDigit), m_edit);
    repeat (4) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  task automatic enter_digit(input int d);
    if (d == 9) begin
      press(2, 8);
      model_event(2);
    end else begin
      for (int k = 0; k < d; k++) begin
        press(1, 8);
        model_event(1);
      end
    end
    press(3, 8);
    model_event(3);
  endtask

  task automatic pulse_reset_count();
    resetCount = 1'b1;
    @(negedge clk);
    resetCount = 1'b0;
    model_clear();
  endtask

  initial begin
    int r;
    int pw [4];
    pw[0] = 2; pw[1] = 9; pw[2] = 5; pw[3] = 3;
    {btn1, btn2, btn3, btn4, btn5} = '0;
    switch1    = 1'b1;
    resetCount = 1'b0;
    rst_n      = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_all("after reset");

    // Glitch shorter than the hold count
    btn1 = 1'b1;
    repeat (2) @(negedge clk);
    btn1 = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("glitch edit", int'(editDigit), 0);

    press(2, 8); model_event(2);
    check_eq("wrap down", int'(editDigit), 9);
    press(1, 8); model_event(1);
    check_eq("wrap up", int'(editDigit), 0);
    press(1, 100); model_event(1);
    check_eq("long hold", int'(editDigit), 1);
    press(2, 8); model_event(2);

    // Entry disabled
    switch1 = 1'b0;
    repeat (10) @(negedge clk);
    press(3, 8);
    press(1, 8);
    check_all("switch off");
    switch1 = 1'b1;
    repeat (10) @(negedge clk);

    // Reset while a button is held
    btn1 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("held through reset", int'(editDigit), 0);
    btn1 = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("release after reset", int'(editDigit), 0);
    press(1, 8); model_event(1);
    check_eq("repress after reset", int'(editDigit), 1);
    press(2, 8); model_event(2);

    // Username 0,0,1,1 with commit latency checked
    press_timed(3);
    press_timed(3);
    press_timed(1);
    press_timed(3);
    press_timed(1);
    press_timed(3);
    check_all("username");

    enter_digit(7);
    check_eq("count5", int'(inputCount), 5);
    press(4, 8); model_event(4);
    check_all("backspace");
    for (int i = 0; i < 4; i++) enter_digit(pw[i]);
    check_all("full");
    press(3, 8); model_event(3);
    check_all("overflow");

    resetCount = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    check_all("resetCount latency");
    @(negedge clk);
    resetCount = 1'b0;

    press(4, 8); model_event(4);
    check_all("backspace empty");

    enter_digit(4);
    press(1, 8); model_event(1);
    btn3 = 1'b1; btn5 = 1'b1;
    repeat (10) @(negedge clk);
    btn3 = 1'b0; btn5 = 1'b0;
    repeat (10) @(negedge clk);
    model_clear();
    check_all("clear beats commit");

    enter_digit(2);
    btn3 = 1'b1;
    repeat (6) @(negedge clk);
    resetCount = 1'b1;
    @(negedge clk);
    resetCount = 1'b0;
    repeat (4) @(negedge clk);
    btn3 = 1'b0;
    repeat (10) @(negedge clk);
    model_clear();
    check_all("resetCount beats commit");

    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 19);
      if (r == 18) begin
        pulse_reset_count();
        repeat (10) @(negedge clk);
      end else begin
        int b;
        if (r < 6) b = 1;
        else if (r < 8) b = 2;
        else if (r < 14 || r == 19) b = 3;
        else if (r < 17) b = 4;
        else b = 5;
        press(b, $urandom_range(8, 15));
        model_event(b);
      end
      check_eq($sformatf("rand%0d count", it), int'(inputCount), m_count);
      check_eq($sformatf("rand%0d edit", it), int'(editDigit), m_edit);
    end
    check_all("random end");

    pulse_reset_count();
    repeat (10) @(negedge clk);
    enter_digit(1);
    enter_digit(0);
`ifdef ENTRY_TIMEOUT_EN
    repeat (20) @(negedge clk);
    check_eq("timeout pending", int'(inputCount), 2);
    repeat (20) @(negedge clk);
    model_clear();
    check_all("timeout fired");
`else
    repeat (1000) @(negedge clk);
    check_all("no timeout");
`endif

    pulse_reset_count();
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) enter_digit(i % 3);
    repeat (100) @(negedge clk);
    check_all("full idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
